dds_sweep_sequencer: RTL and testbench

- Frequency-sweep controller between spi_in/cmd_decoder and the oscillator voices.
- Sits on the decoded SPI command stream: forwards ordinary host commands to cmd_decoder and consumes the sweep-configuration commands itself.
- When enabled, autonomously issues timed tuning-word writes to one voice, stepping from a start word to a stop word.
- Arbitrates the single cmd_decoder write port between host traffic (priority) and sweep writes.

---
 rtl/dds_sweep_pkg.sv | 27 ++
 rtl/sweep_timer.sv | 66 ++++++
 rtl/dds_sweep_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_dds_sweep_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_sweep_pkg.sv
// Shared definitions for the DDS frequency-sweep sequencer: the sweep
// configuration command codes, control-word bit positions and FSM states.
package dds_sweep_pkg;

    localparam logic [7:0] CMD_SWEEP_START    = 8'hA0;
    localparam logic [7:0] CMD_SWEEP_STOP     = 8'hA1;
    localparam logic [7:0] CMD_SWEEP_STEP     = 8'hA2;
    localparam logic [7:0] CMD_SWEEP_INTERVAL = 8'hA3;
    localparam logic [7:0] CMD_SWEEP_CTRL     = 8'hA4;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_TARGET_BIT = 1;
    localparam int CTRL_LOOP_BIT   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } sweep_state_e;

    // True for the codes this block consumes instead of forwarding.
    function automatic logic is_sweep_cmd(input logic [7:0] code);
        return (code >= CMD_SWEEP_START) && (code <= CMD_SWEEP_CTRL);
    endfunction

endpackage

// File: rtl/sweep_timer.sv
// Interval timer for the sweep: a prescaler of PRESCALE cycles nested inside
// an interval down-counter. After a restart pulse in cycle I, expire_o pulses
// in cycle I + PRESCALE*(interval+1) - 1, so the FSM step that follows lands
// exactly one full period after the restart. The interval is sampled at
// restart, so a new interval only applies to the following period.
// Shortest achievable period is two cycles (PRESCALE=1, interval=0).
module sweep_timer #(
    parameter int PRESCALE = 256
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        restart_i,
    input  logic [15:0] interval_i,
    output logic        expire_o
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [15:0]   ivl_q, ivl_d;
    logic          run_q, run_d;
    logic          last;

    // Remaining cycles are ivl_q*PRESCALE + pre_q; fire when one (or none) remains.
    always_comb begin
        last     = (PRESCALE > 1) ? ((ivl_q == 16'd0) && (pre_q <= PW'(1)))
                                  : (ivl_q <= 16'd1);
        expire_o = run_q && last;
    end

    // Next-state for the prescaler / interval counters.
    always_comb begin
        pre_d = pre_q;
        ivl_d = ivl_q;
        run_d = run_q;
        if (restart_i) begin
            pre_d = PRE_MAX;
            ivl_d = interval_i;
            run_d = 1'b1;
        end else if (run_q) begin
            if (last) begin
                run_d = 1'b0;
            end else if (pre_q == '0) begin
                pre_d = PRE_MAX;
                ivl_d = ivl_q - 16'd1;
            end else begin
                pre_d = pre_q - PW'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            ivl_q <= '0;
            run_q <= 1'b0;
        end else begin
            pre_q <= pre_d;
            ivl_q <= ivl_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/dds_sweep_sequencer.sv
// Frequency-sweep controller sitting between the SPI command stream and
// cmd_decoder. Ordinary host commands are forwarded with one cycle of
// latency; sweep configuration commands (0xA0-0xA4) are consumed here.
// When enabled, the FSM writes tuning words from start to stop, one write per
// timer period, sharing the cmd_decoder port with forwarded host traffic.
//
// Handshake: cmd_valid is a single-cycle strobe with cmd_word/data_word valid
// in the same cycle; there is no back-pressure. A forwarded host command owns
// the port in its cycle; a sweep write that coincides with it is held and
// issued the following cycle. Outside a strobe cmd_word/data_word read as 0.
module dds_sweep_sequencer
    import dds_sweep_pkg::*;
#(
    parameter int         DATA_WIDTH    = 16,
    parameter int         TUNING_WIDTH  = 16,
    parameter int         PRESCALE      = 256,
    parameter logic [7:0] OSC0_TUNE_CMD = 8'h01,
    parameter logic [7:0] OSC1_TUNE_CMD = 8'h11
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,
    input  logic [7:0]              host_cmd_word,
    input  logic [DATA_WIDTH-1:0]   host_data_word,
    input  logic                    host_cmd_valid,
    output logic [7:0]              cmd_word,
    output logic [DATA_WIDTH-1:0]   data_word,
    output logic                    cmd_valid,
    output logic                    sweep_active,
    output logic                    sweep_done,
    output logic [TUNING_WIDTH-1:0] cur_tune,
    output sweep_state_e            dbg_state
);

    localparam int TW = TUNING_WIDTH;

    // Configuration registers
    logic [TW-1:0] start_q, stop_q, step_q;
    logic [15:0]   interval_q;
    logic          target_q, loop_q;

    // Host forwarding register
    logic                  fwd_valid_q;
    logic [7:0]            fwd_cmd_q;
    logic [DATA_WIDTH-1:0] fwd_data_q;

    // Sweep state
    sweep_state_e  state_q, state_d;
    logic [TW-1:0] cur_q, cur_d;
    logic          dir_up_q, dir_up_d;
    logic          wrap_q, wrap_d;
    logic          done_q, done_d;
    logic [TW-1:0] tune_q, tune_d;

    // Write held back by a host collision
    logic          hold_q, hold_d;
    logic [7:0]    hold_cmd_q, hold_cmd_d;
    logic [TW-1:0] hold_data_q, hold_data_d;

    logic          host_is_sweep, host_fwd, ctrl_wr, ctrl_en;
    logic          timer_restart, timer_expire;
    logic [7:0]    sweep_code;
    logic [TW:0]   up_sum;
    logic [TW-1:0] up_next, dn_next, step_next;

    // Command decode and the next clamped sweep value.
    always_comb begin
        host_is_sweep = is_sweep_cmd(host_cmd_word);
        host_fwd      = host_cmd_valid && !host_is_sweep;
        ctrl_wr       = host_cmd_valid && (host_cmd_word == CMD_SWEEP_CTRL);
        ctrl_en       = host_data_word[CTRL_EN_BIT];
        sweep_code    = target_q ? OSC1_TUNE_CMD : OSC0_TUNE_CMD;
        // One extra bit keeps the upward compare from wrapping past all-ones.
        up_sum        = {1'b0, cur_q} + {1'b0, step_q};
        up_next       = (up_sum >= {1'b0, stop_q}) ? stop_q : up_sum[TW-1:0];
        dn_next       = ((cur_q >= step_q) && ((cur_q - step_q) > stop_q))
                        ? (cur_q - step_q) : stop_q;
        step_next     = dir_up_q ? up_next : dn_next;
    end

    // Configuration writes and host forwarding register.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q     <= '0;
            stop_q      <= '0;
            step_q      <= '0;
            interval_q  <= '0;
            target_q    <= 1'b0;
            loop_q      <= 1'b0;
            fwd_valid_q <= 1'b0;
            fwd_cmd_q   <= '0;
            fwd_data_q  <= '0;
        end else begin
            fwd_valid_q <= host_fwd;
            if (host_fwd) begin
                fwd_cmd_q  <= host_cmd_word;
                fwd_data_q <= host_data_word;
            end
            if (host_cmd_valid) begin
                case (host_cmd_word)
                    CMD_SWEEP_START:    start_q    <= TW'(host_data_word);
                    CMD_SWEEP_STOP:     stop_q     <= TW'(host_data_word);
                    CMD_SWEEP_STEP:     step_q     <= TW'(host_data_word);
                    CMD_SWEEP_INTERVAL: interval_q <= 16'(host_data_word);
                    CMD_SWEEP_CTRL: begin
                        target_q <= host_data_word[CTRL_TARGET_BIT];
                        loop_q   <= host_data_word[CTRL_LOOP_BIT];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Sweep FSM next-state, sweep value stepping and collision hold.
    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        dir_up_d      = dir_up_q;
        wrap_d        = wrap_q;
        done_d        = done_q;
        tune_d        = tune_q;
        timer_restart = 1'b0;
        hold_d        = 1'b0;
        hold_cmd_d    = hold_cmd_q;
        hold_data_d   = hold_data_q;

        case (state_q)
            IDLE: ;
            ISSUE: begin
                timer_restart = 1'b1;
                tune_d        = cur_q;
                if ((step_q == '0) || ((cur_q == stop_q) && !loop_q)) begin
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                    if (cur_q == stop_q) begin
                        // Reload now; the next expiry reissues start unstepped.
                        cur_d  = start_q;
                        wrap_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (timer_expire) begin
                    state_d = ISSUE;
                    if (wrap_q) begin
                        wrap_d = 1'b0;
                    end else begin
                        cur_d = step_next;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Host forward owns the port; park the sweep write for one cycle.
        if (fwd_valid_q && (state_q == ISSUE)) begin
            hold_d      = 1'b1;
            hold_cmd_d  = sweep_code;
            hold_data_d = cur_q;
        end else if (fwd_valid_q && hold_q) begin
            hold_d = 1'b1;
        end

        // A control write (re)starts or stops the sweep from any state.
        if (ctrl_wr) begin
            hold_d = 1'b0;
            if (ctrl_en) begin
                state_d  = ISSUE;
                cur_d    = start_q;
                dir_up_d = (stop_q >= start_q);
                wrap_d   = 1'b0;
                done_d   = 1'b0;
            end else if ((state_q == ISSUE) || (state_q == WAIT)) begin
                state_d = IDLE;
                wrap_d  = 1'b0;
            end
        end
    end

    // Sweep FSM registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            dir_up_q    <= 1'b0;
            wrap_q      <= 1'b0;
            done_q      <= 1'b0;
            tune_q      <= '0;
            hold_q      <= 1'b0;
            hold_cmd_q  <= '0;
            hold_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            dir_up_q    <= dir_up_d;
            wrap_q      <= wrap_d;
            done_q      <= done_d;
            tune_q      <= tune_d;
            hold_q      <= hold_d;
            hold_cmd_q  <= hold_cmd_d;
            hold_data_q <= hold_data_d;
        end
    end

    // Output port arbitration: host forward, then held write, then live issue.
    always_comb begin
        cmd_valid = 1'b0;
        cmd_word  = '0;
        data_word = '0;
        if (fwd_valid_q) begin
            cmd_valid = 1'b1;
            cmd_word  = fwd_cmd_q;
            data_word = fwd_data_q;
        end else if (hold_q) begin
            cmd_valid = 1'b1;
            cmd_word  = hold_cmd_q;
            data_word = DATA_WIDTH'(hold_data_q);
        end else if (state_q == ISSUE) begin
            cmd_valid = 1'b1;
            cmd_word  = sweep_code;
            data_word = DATA_WIDTH'(cur_q);
        end
    end

    assign sweep_active = (state_q == ISSUE) || (state_q == WAIT);
    assign sweep_done   = done_q;
    assign cur_tune     = tune_q;
    assign dbg_state    = state_q;

    sweep_timer #(
        .PRESCALE(PRESCALE)
    ) u_timer (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .restart_i (timer_restart),
        .interval_i(interval_q),
        .expire_o  (timer_expire)
    );

endmodule

// File: tb/tb_dds_sweep_sequencer.sv
// Bench for dds_sweep_sequencer with PRESCALE=4: a table of host commands,
// directed multi-cycle sweep sequences and randomized one-shot sweeps, all
// checked against an arithmetic model of the sweep word/timing rules.
module tb_dds_sweep_sequencer;
    import dds_sweep_pkg::*;

    localparam int P = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   host_cmd_word = '0;
    logic [15:0]  host_data_word = '0;
    logic         host_cmd_valid = 1'b0;
    logic [7:0]   cmd_word;
    logic [15:0]  data_word;
    logic         cmd_valid;
    logic         sweep_active;
    logic         sweep_done;
    logic [15:0]  cur_tune;
    sweep_state_e dbg_state;

    dds_sweep_sequencer #(
        .DATA_WIDTH(16), .TUNING_WIDTH(16), .PRESCALE(P),
        .OSC0_TUNE_CMD(8'h01), .OSC1_TUNE_CMD(8'h11)
    ) dut (
        .sys_clk(clk), .rst_n(rst_n),
        .host_cmd_word(host_cmd_word), .host_data_word(host_data_word),
        .host_cmd_valid(host_cmd_valid),
        .cmd_word(cmd_word), .data_word(data_word), .cmd_valid(cmd_valid),
        .sweep_active(sweep_active), .sweep_done(sweep_done),
        .cur_tune(cur_tune), .dbg_state(dbg_state)
    );

    // Clock / reset-independent cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Every write on the cmd_decoder port, packed as {cycle, cmd, data}
    logic [55:0] mon_q[$];
    logic [55:0] exp_q[$];
    always @(posedge clk) begin
        #2;
        if (cmd_valid) mon_q.push_back({cyc[31:0], cmd_word, data_word});
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick(1);
    endtask

    // Driver tasks
    task automatic host_cmd(input logic [7:0] c, input logic [15:0] d);
        host_cmd_word  = c;
        host_data_word = d;
        host_cmd_valid = 1'b1;
        tick(1);
        host_cmd_valid = 1'b0;
        host_cmd_word  = '0;
        host_data_word = '0;
    endtask

    task automatic configure(input int s, input int e, input int st, input int ivl);
        host_cmd(8'hA0, 16'(s));
        host_cmd(8'hA1, 16'(e));
        host_cmd(8'hA2, 16'(st));
        host_cmd(8'hA3, 16'(ivl));
    endtask

    // Returns the cycle in which the control write was presented.
    task automatic enable(input logic [2:0] ctrl, output int t);
        t = cyc;
        host_cmd(8'hA4, {13'd0, ctrl});
    endtask

    task automatic push_exp(input int t, input logic [7:0] c, input int d);
        exp_q.push_back({t[31:0], c, d[15:0]});
    endtask

    // Reference model: sweep words and issue cycles from the sweep rules,
    // with an optional host forward that takes the port at host_t.
    task automatic build_expected(input int s, input int e, input int st, input int ivl,
                                  input int max_n, input bit lp, input logic [7:0] code,
                                  input int t0, input int host_t,
                                  input logic [7:0] hcode, input logic [15:0] hdata);
        int w;
        int t;
        int k;
        w = s;
        t = t0;
        k = 0;
        while (k < max_n) begin
            if (t == host_t) begin
                push_exp(t, hcode, int'(hdata));
                push_exp(t + 1, code, w);
            end else begin
                push_exp(t, code, w);
            end
            k++;
            if (st == 0) break;
            if (w == e) begin
                if (!lp) break;
                w = s;
            end else if (e >= s) begin
                w = (w + st > e) ? e : w + st;
            end else begin
                w = (w - st < e) ? e : w - st;
            end
            t += P * (ivl + 1);
        end
    endtask

    task automatic compare(input string name);
        check({name, " write count"}, 64'(mon_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
            check($sformatf("%s write %0d {cyc,cmd,data}", name, i), 64'(mon_q[i]), 64'(exp_q[i]));
    endtask

    task automatic clear_queues();
        mon_q.delete();
        exp_q.delete();
    endtask

    typedef struct {
        logic [7:0]  c;
        logic [15:0] d;
        logic        fwd;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int t, t0, t1;
        int s, e, st, ivl, delta, up, tg;
        logic [55:0] last;

        // Reset: outputs stay zero even with host traffic present
        tick(2);
        host_cmd_word  = 8'h01;
        host_data_word = 16'h1234;
        host_cmd_valid = 1'b1;
        tick(1);
        check("reset cmd_valid", 64'(cmd_valid), 64'd0);
        check("reset cmd_word", 64'(cmd_word), 64'd0);
        check("reset data_word", 64'(data_word), 64'd0);
        check("reset sweep_active", 64'(sweep_active), 64'd0);
        check("reset sweep_done", 64'(sweep_done), 64'd0);
        check("reset cur_tune", 64'(cur_tune), 64'd0);
        check("reset state", 64'(dbg_state), 64'(IDLE));
        host_cmd_valid = 1'b0;
        host_cmd_word  = '0;
        host_data_word = '0;
        rst_n = 1'b1;
        tick(2);

        // Forwarding table; the A0-A3 rows also set up the next sweep
        vecs[0] = '{8'h01, 16'h1234, 1'b1};
        vecs[1] = '{8'hA0, 16'd100, 1'b0};
        vecs[2] = '{8'hA1, 16'd130, 1'b0};
        vecs[3] = '{8'hA2, 16'd10, 1'b0};
        vecs[4] = '{8'hA3, 16'd0, 1'b0};
        vecs[5] = '{8'h7F, 16'hBEEF, 1'b1};
        vecs[6] = '{8'hA5, 16'h5A5A, 1'b1};
        vecs[7] = '{8'h9F, 16'h0001, 1'b1};
        for (int i = 0; i < 8; i++) begin
            host_cmd(vecs[i].c, vecs[i].d);
            check($sformatf("fwd[%0d] cmd_valid", i), 64'(cmd_valid), 64'(vecs[i].fwd));
            check($sformatf("fwd[%0d] cmd_word", i), 64'(cmd_word),
                  vecs[i].fwd ? 64'(vecs[i].c) : 64'd0);
            check($sformatf("fwd[%0d] data_word", i), 64'(data_word),
                  vecs[i].fwd ? 64'(vecs[i].d) : 64'd0);
            tick(1);
            check($sformatf("fwd[%0d] pulse end", i), 64'(cmd_valid), 64'd0);
        end

        // Up one-shot 100..130 step 10 on osc0
        clear_queues();
        enable(3'b001, t);
        check("up active at T+1", 64'(sweep_active), 64'd1);
        check("up first valid at T+1", 64'(cmd_valid), 64'd1);
        tick(4 * P + 6);
        build_expected(100, 130, 10, 0, 100, 1'b0, 8'h01, t + 1, -1, 8'h00, 16'h0000);
        compare("up");
        check("up sweep_done", 64'(sweep_done), 64'd1);
        check("up sweep_active", 64'(sweep_active), 64'd0);
        check("up cur_tune", 64'(cur_tune), 64'd130);

        // Down with clamp and loop on osc1, then disable
        configure(50, 20, 20, 0);
        clear_queues();
        enable(3'b111, t);
        check("down done cleared", 64'(sweep_done), 64'd0);
        wait_until(t + 26);
        host_cmd(8'hA4, 16'h0000);
        tick(20);
        build_expected(50, 20, 20, 0, 7, 1'b1, 8'h11, t + 1, -1, 8'h00, 16'h0000);
        compare("down loop");
        check("down sweep_done", 64'(sweep_done), 64'd0);
        check("down sweep_active", 64'(sweep_active), 64'd0);
        check("down cur_tune", 64'(cur_tune), 64'd50);

        // Saturation at the top of the tuning range
        configure(16'hFFF0, 16'hFFFF, 16'h0020, 0);
        clear_queues();
        enable(3'b001, t);
        tick(15);
        build_expected(16'hFFF0, 16'hFFFF, 16'h0020, 0, 100, 1'b0, 8'h01, t + 1, -1, 8'h00, 16'h0000);
        compare("saturate");
        check("saturate sweep_done", 64'(sweep_done), 64'd1);
        check("saturate cur_tune", 64'(cur_tune), 64'hFFFF);

        // Host forward collides with the second sweep issue
        configure(100, 130, 10, 0);
        clear_queues();
        enable(3'b001, t);
        wait_until(t + 4);
        host_cmd(8'h02, 16'hABCD);
        tick(20);
        build_expected(100, 130, 10, 0, 100, 1'b0, 8'h01, t + 1, t + 5, 8'h02, 16'hABCD);
        compare("collision");
        check("collision sweep_done", 64'(sweep_done), 64'd1);

        // Asynchronous reset during WAIT
        configure(100, 1000, 10, 0);
        clear_queues();
        enable(3'b001, t);
        wait_until(t + 6);
        check("pre-reset writes", 64'(mon_q.size()), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset sweep_active", 64'(sweep_active), 64'd0);
        check("async reset cmd_valid", 64'(cmd_valid), 64'd0);
        check("async reset cur_tune", 64'(cur_tune), 64'd0);
        check("async reset sweep_done", 64'(sweep_done), 64'd0);
        check("async reset state", 64'(dbg_state), 64'(IDLE));
        tick(2);
        rst_n = 1'b1;
        mon_q.delete();
        tick(40);
        check("post-reset writes", 64'(mon_q.size()), 64'd0);
        check("post-reset sweep_active", 64'(sweep_active), 64'd0);

        // Re-enable mid-sweep with a new target, then disable
        configure(100, 1000, 10, 1);
        clear_queues();
        enable(3'b011, t0);
        wait_until(t0 + 12);
        enable(3'b001, t1);
        wait_until(t1 + 18);
        host_cmd(8'hA4, 16'h0000);
        tick(20);
        build_expected(100, 1000, 10, 1, 2, 1'b0, 8'h11, t0 + 1, -1, 8'h00, 16'h0000);
        build_expected(100, 1000, 10, 1, 3, 1'b0, 8'h01, t1 + 1, -1, 8'h00, 16'h0000);
        compare("re-enable");
        check("re-enable sweep_active", 64'(sweep_active), 64'd0);
        check("re-enable sweep_done", 64'(sweep_done), 64'd0);

        // Randomized one-shot sweeps
        for (int r = 0; r < 10; r++) begin
            s     = int'($urandom_range(0, 65535));
            delta = int'($urandom_range(0, 120));
            up    = int'($urandom_range(0, 1));
            e     = (up != 0) ? ((s + delta > 65535) ? 65535 : s + delta)
                              : ((s - delta < 0) ? 0 : s - delta);
            st    = int'($urandom_range(0, 50));
            ivl   = int'($urandom_range(0, 2));
            tg    = int'($urandom_range(0, 1));
            if (r == 0) st = 0;
            if (r == 1) e = s;
            configure(s, e, st, ivl);
            clear_queues();
            enable({1'b0, tg[0], 1'b1}, t);
            build_expected(s, e, st, ivl, 1000, 1'b0, (tg != 0) ? 8'h11 : 8'h01,
                           t + 1, -1, 8'h00, 16'h0000);
            tick(exp_q.size() * P * (ivl + 1) + 8);
            compare($sformatf("rand%0d", r));
            check($sformatf("rand%0d sweep_done", r), 64'(sweep_done), 64'd1);
            last = exp_q[exp_q.size() - 1];
            check($sformatf("rand%0d cur_tune", r), 64'(cur_tune), 64'(last[15:0]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
